// File: rtl/ife_scan_ctrl.sv
// 3x3 window scan controller: walks a square image in raster order, fetches nine taps per
// pixel, waits for the datapath result and writes it back. Define IFE_ZERO_PAD_EN for zero-padded borders.
module ife_scan_ctrl #(
   parameter int IMG_LOG2 = 7,
   parameter int TAPS     = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ready,
   output logic                  busy,
   input  logic [1:0]            sel,
   output logic [2*IMG_LOG2-1:0] iaddr,
   input  logic [7:0]            idata,
   output logic                  tap_valid,
   output logic [7:0]            tap_data,
   output logic [3:0]            tap_idx,
   output logic [1:0]            tap_mode,
   input  logic                  res_valid,
   input  logic [7:0]            res_data,
   output logic [2*IMG_LOG2-1:0] addr,
   output logic                  wen,
   output logic [7:0]            data_wr
);
   localparam int                  AW     = 2 * IMG_LOG2;
   localparam logic [IMG_LOG2-1:0] C_ONE  = 1;
   localparam logic [AW-1:0]       P_ONE  = 1;
   localparam logic [3:0]          K_ONE  = 4'd1;
   localparam logic [3:0]          K_LAST = 4'(TAPS - 1);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT_RES, WRITE, FINISH} state_t;

   // {row step, col step}, each 0/1/2 meaning -1/0/+1
   function automatic logic [3:0] tap_rc(input logic [3:0] k);
      case (k)
         4'd0:    tap_rc = 4'b0000;
         4'd1:    tap_rc = 4'b0001;
         4'd2:    tap_rc = 4'b0010;
         4'd3:    tap_rc = 4'b0100;
         4'd4:    tap_rc = 4'b0101;
         4'd5:    tap_rc = 4'b0110;
         4'd6:    tap_rc = 4'b1000;
         4'd7:    tap_rc = 4'b1001;
         default: tap_rc = 4'b1010;
      endcase
   endfunction

   function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] p, input logic [3:0] k);
      logic [IMG_LOG2-1:0] r, c;
      logic [3:0]          rc;
      r  = p[AW-1:IMG_LOG2];
      c  = p[IMG_LOG2-1:0];
      rc = tap_rc(k);
      if      (rc[3:2] == 2'd0 && r != '0) r = r - C_ONE;
      else if (rc[3:2] == 2'd2 && r != '1) r = r + C_ONE;
      if      (rc[1:0] == 2'd0 && c != '0) c = c - C_ONE;
      else if (rc[1:0] == 2'd2 && c != '1) c = c + C_ONE;
      return {r, c};
   endfunction

`ifdef IFE_ZERO_PAD_EN
   function automatic logic tap_oob(input logic [AW-1:0] p, input logic [3:0] k);
      logic [3:0] rc;
      rc = tap_rc(k);
      return (rc[3:2] == 2'd0 && p[AW-1:IMG_LOG2] == '0) ||
             (rc[3:2] == 2'd2 && p[AW-1:IMG_LOG2] == '1) ||
             (rc[1:0] == 2'd0 && p[IMG_LOG2-1:0] == '0) ||
             (rc[1:0] == 2'd2 && p[IMG_LOG2-1:0] == '1);
   endfunction
`endif

   state_t        state_q, state_d;
   logic [3:0]    k_q, k_d, k_inc;
   logic [AW-1:0] pix_q, pix_d, pix_inc;
   logic          wait1_q, wait1_d;
   logic          busy_q, busy_d;
   logic [AW-1:0] iaddr_q, iaddr_d;
   logic          tap_valid_q, tap_valid_d;
   logic [7:0]    tap_data_q, tap_data_d;
   logic [3:0]    tap_idx_q, tap_idx_d;
   logic [1:0]    tap_mode_q, tap_mode_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          wen_q, wen_d;
   logic [7:0]    data_wr_q, data_wr_d;

   assign k_inc   = k_q + K_ONE;
   assign pix_inc = pix_q + P_ONE;

   // iaddr is registered, so each transition preloads the address of the tap fetched next
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      pix_d       = pix_q;
      wait1_d     = wait1_q;
      busy_d      = busy_q;
      iaddr_d     = iaddr_q;
      tap_valid_d = 1'b0;
      tap_data_d  = tap_data_q;
      tap_idx_d   = tap_idx_q;
      tap_mode_d  = tap_mode_q;
      addr_d      = addr_q;
      wen_d       = 1'b0;
      data_wr_d   = data_wr_q;
      case (state_q)
         IDLE: begin
            if (ready) begin
               state_d    = FETCH;
               busy_d     = 1'b1;
               tap_mode_d = sel;
               pix_d      = '0;
               k_d        = '0;
               iaddr_d    = tap_addr('0, 4'd0);
            end
         end
         FETCH: begin
            tap_valid_d = 1'b1;
            tap_idx_d   = k_q;
`ifdef IFE_ZERO_PAD_EN
            tap_data_d  = tap_oob(pix_q, k_q) ? 8'd0 : idata;
`else
            tap_data_d  = idata;
`endif
            if (k_q == K_LAST) begin
               state_d = WAIT_RES;
               wait1_d = 1'b1;
            end else begin
               k_d     = k_inc;
               iaddr_d = tap_addr(pix_q, k_inc);
            end
         end
         WAIT_RES: begin
            // the first WAIT_RES cycle still carries tap 8, so a result there is premature
            wait1_d = 1'b0;
            if (!wait1_q && res_valid) begin
               state_d   = WRITE;
               wen_d     = 1'b1;
               addr_d    = pix_q;
               data_wr_d = res_data;
            end
         end
         WRITE: begin
            if (pix_q == '1) begin
               state_d = FINISH;
            end else begin
               state_d = FETCH;
               pix_d   = pix_inc;
               k_d     = '0;
               iaddr_d = tap_addr(pix_inc, 4'd0);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         k_q         <= '0;
         pix_q       <= '0;
         wait1_q     <= 1'b0;
         busy_q      <= 1'b0;
         iaddr_q     <= '0;
         tap_valid_q <= 1'b0;
         tap_data_q  <= '0;
         tap_idx_q   <= '0;
         tap_mode_q  <= '0;
         addr_q      <= '0;
         wen_q       <= 1'b0;
         data_wr_q   <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         pix_q       <= pix_d;
         wait1_q     <= wait1_d;
         busy_q      <= busy_d;
         iaddr_q     <= iaddr_d;
         tap_valid_q <= tap_valid_d;
         tap_data_q  <= tap_data_d;
         tap_idx_q   <= tap_idx_d;
         tap_mode_q  <= tap_mode_d;
         addr_q      <= addr_d;
         wen_q       <= wen_d;
         data_wr_q   <= data_wr_d;
      end
   end

   assign busy      = busy_q;
   assign iaddr     = iaddr_q;
   assign tap_valid = tap_valid_q;
   assign tap_data  = tap_data_q;
   assign tap_idx   = tap_idx_q;
   assign tap_mode  = tap_mode_q;
   assign addr      = addr_q;
   assign wen       = wen_q;
   assign data_wr   = data_wr_q;

endmodule

// File: doc/ife_scan_ctrl.md
IFE_SCAN_CTRL -- requirements
Module: ife_scan_ctrl

Interface
REQ-001 SHALL have parameter IMG_LOG2, default 7, meaning log2 of image side (128x128 frame, 14-bit addresses).
REQ-002 SHALL have parameter TAPS, default 9, meaning window taps per pixel (3x3, raster order), fixed.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 ready  in  1  host start request, sampled in IDLE only.
REQ-007 busy  out  1  frame in progress.
REQ-008 sel  in  2  filter mode, latched at frame start.
REQ-009 iaddr  out  14  image read address, {row,col}.
REQ-010 idata  in  8  image pixel for the iaddr driven in the same cycle, sampled at the closing rising edge.
REQ-011 tap_valid  out  1  window tap present on tap_data.
REQ-012 tap_data  out  8  tap pixel value.
REQ-013 tap_idx  out  4  tap index 0..8, index = 3*(dr+1)+(dc+1).
REQ-014 tap_mode  out  2  latched sel, forwarded to datapath.
REQ-015 res_valid  in  1  datapath result strobe.
REQ-016 res_data  in  8  datapath result.
REQ-017 addr  out  14  result memory address.
REQ-018 wen  out  1  result memory write enable, 1 = write.
REQ-019 data_wr  out  8  result memory write data.

Function
REQ-020 States SHALL be IDLE, FETCH, WAIT_RES, WRITE, FINISH.
REQ-021 IDLE -> FETCH when ready=1 and reset=0; busy=1 from the next cycle; sel latched into tap_mode; pixel counter = 0.
REQ-022 FETCH SHALL last exactly 9 cycles; cycle k drives iaddr for tap k at (row+dr, col+dc), dr,dc in {-1,0,1}, raster order.
REQ-023 Tap k SHALL be registered: tap_valid=1, tap_idx=k, tap_data=captured idata in the cycle after FETCH cycle k; tap_valid=0 at all other times.
REQ-024 FETCH -> WAIT_RES after cycle 8; tap 8 is presented in the first WAIT_RES cycle.
REQ-025 res_valid SHALL be honored only from the second WAIT_RES cycle onward; it is ignored in every other state and cycle.
REQ-026 WAIT_RES -> WRITE on honored res_valid; res_data latched; no timeout; WAIT_RES holds indefinitely.
REQ-027 WRITE SHALL be exactly one cycle: wen=1, addr=pixel counter, data_wr=latched res_data.
REQ-028 WRITE -> FETCH with pixel counter +1 (raster, col fastest); after pixel 16383 -> FINISH.
REQ-029 FINISH SHALL be one cycle with busy=1, then IDLE with busy=0; the counter does not wrap into a new frame.
REQ-030 Minimum per-pixel period SHALL be 12 cycles (9 FETCH + 2 WAIT_RES + 1 WRITE).
REQ-031 ready and sel changes while busy=1 SHALL be ignored.
REQ-032 wen SHALL be 0 outside WRITE; addr and data_wr hold their last values.
REQ-033 Border taps SHALL clamp coordinates into 0..127 per axis (edge replication) unless REQ-038 applies.

Reset
REQ-034 reset=1 at any rising edge SHALL force IDLE and set pixel counter=0, busy=0, wen=0, tap_valid=0, tap_idx=0, tap_data=0, tap_mode=0, iaddr=0, addr=0, data_wr=0.
REQ-035 Reset mid-frame SHALL abort with no further write; the next frame restarts at pixel 0.
REQ-036 ready held high during reset SHALL start a frame on the first non-reset edge.

Configuration
REQ-037 Macro IFE_ZERO_PAD_EN SHALL select border handling.
REQ-038 With IFE_ZERO_PAD_EN defined: out-of-image taps SHALL present tap_data=0 (tap still issued, same 9-cycle timing) and iaddr holds the clamped value; without it, REQ-033 clamping applies.

Verification
REQ-039 reset=1 with ready=1 for 2 cycles, then reset=0 -> busy=0 during reset, busy=1 one cycle after release.
REQ-040 Pixel 0, macro undefined -> iaddr sequence 0,0,1,0,0,1,128,128,129; with macro -> tap_data=0 for taps 0,1,2,3,6.
REQ-041 Pixel (5,5), addr 645 -> iaddr 516,517,518,644,645,646,772,773,774; tap_idx 0..8 on consecutive cycles.
REQ-042 res_valid asserted during FETCH, then 3 cycles late in WAIT_RES with res_data=8'hA5 -> single wen pulse, addr=pixel index, data_wr=8'hA5.
REQ-043 Full frame, max-filter model, sel=2 -> 16384 writes, busy falls 2 cycles after the addr 16383 write, memory matches golden_max.dat with 0 errors.
REQ-044 reset asserted mid-frame at pixel 300 -> wen=0 and busy=0 next cycle; a new ready restarts the write sequence at addr 0.
